// File: rtl/des_pkg.sv
// Shared constants for the DES substitution stage: S-box tables, chunk widths, FSM states.
// Each box is 64 nibbles, row-major, entry 0 in the top nibble.
package des_pkg;
  localparam int SB_IN_W  = 6;
  localparam int SB_OUT_W = 4;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

  localparam logic [1:8][255:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };
endpackage

// File: rtl/des_sbox_lut.sv
// Combinational 6->4 ROM for a single DES S-box.
module des_sbox_lut
  import des_pkg::*;
#(
  parameter int BOX = 1
) (
  input  logic [SB_IN_W-1:0]  chunk,
  output logic [SB_OUT_W-1:0] val
);
  localparam logic [255:0] TBL = SBOX[BOX];

  // row = {b6,b1}, col = b5..b2; entry 0 sits at the top nibble, so index from the top
  logic [5:0] rev_idx;
  assign rev_idx = 6'd63 - {chunk[5], chunk[0], chunk[4:1]};
  assign val     = TBL[{rev_idx, 2'b00} +: SB_OUT_W];
endmodule

// File: rtl/des_sbox_engine.sv
// Iterative DES S1..S8 substitution: LANES lookups per cycle, one word in flight.
module des_sbox_engine
  import des_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [47:0] DIN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] DOUT
);
  localparam int NCYC = 8 / LANES;
  localparam int CW   = $clog2(NCYC) + 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
    $error("des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  state_e                     state;
  logic [47:0]                in_sr;
  logic [31:0]                out_sr, out_nxt, dout_q;
  logic [CW-1:0]              cnt;
  logic                       last;
  logic [SB_OUT_W-1:0]        lut_out [LANES][8];
  logic [SB_OUT_W-1:0]        lane_res [LANES];
  logic [SB_OUT_W*LANES-1:0]  res_cat;

  // Lane l only ever serves boxes l, l+LANES, ...; other mux inputs are tied off.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [SB_IN_W-1:0] chunk;
    logic [2:0]         sel;
    assign chunk = in_sr[47-SB_IN_W*l -: SB_IN_W];
    assign sel   = 3'(int'(cnt) * LANES + l);
    for (genvar b = 0; b < 8; b++) begin : g_box
      if (b % LANES == l) begin : g_rom
        des_sbox_lut #(.BOX(b + 1)) u_lut (.chunk(chunk), .val(lut_out[l][b]));
      end else begin : g_nc
        assign lut_out[l][b] = '0;
      end
    end
    assign lane_res[l] = lut_out[l][sel];
  end

  always_comb begin
    res_cat = '0;
    for (int l = 0; l < LANES; l++) res_cat[SB_OUT_W*(LANES-1-l) +: SB_OUT_W] = lane_res[l];
  end

  // At LANES=8 the shift clears the whole register, which is what we want.
  assign out_nxt   = (out_sr << (SB_OUT_W * LANES)) | 32'(res_cat);
  assign last      = (cnt == CW'(NCYC - 1));
  assign IN_READY  = (state == IDLE) || (state == DONE && OUT_READY);
  assign OUT_VALID = (state == DONE);
  assign DOUT      = dout_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      in_sr  <= '0;
      out_sr <= '0;
      dout_q <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (IN_VALID) begin
          in_sr <= DIN;
          cnt   <= '0;
          state <= BUSY;
        end
        BUSY: begin
          in_sr  <= in_sr << (SB_IN_W * LANES);
          out_sr <= out_nxt;
          cnt    <= cnt + 1'b1;
          if (last) begin
            dout_q <= out_nxt;
            state  <= DONE;
          end
        end
        DONE: if (OUT_READY) begin
          if (IN_VALID) begin
            in_sr <= DIN;
            cnt   <= '0;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
